// File: rtl/fixed_to_float_enc.sv
// fixed_to_float_enc: 12-bit unsigned integer to 8-bit float {E[2:0], M[4:0]}.
// Optional round-half-up on the final step: define FIXED_TO_FLOAT_ROUND_EN.
module fixed_to_float_enc (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_float,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t      state;
    logic [11:0] sh;
    logic [2:0]  e;
    logic        guard;
    logic [7:0]  res;

`ifdef FIXED_TO_FLOAT_ROUND_EN
    logic [5:0] mr;

    // Final-step packing with round-half-up, mantissa carry and saturation
    always_comb begin
        mr  = {1'b0, sh[4:0]} + {5'd0, guard};
        res = {e, mr[4:0]};
        if (mr[5]) begin
            if (e == 3'd7) begin
                res = 8'hFF;
            end else begin
                res = {e + 3'd1, 5'd16};
            end
        end
    end
`else
    logic unused_guard;
    assign unused_guard = guard;

    // Final-step packing with truncation toward zero
    always_comb begin
        res = {e, sh[4:0]};
    end
`endif

    // Control FSM: load, normalize one bit per cycle, hold result until taken
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sh        <= 12'd0;
            e         <= 3'd0;
            guard     <= 1'b0;
            out_valid <= 1'b0;
            out_float <= 8'd0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh       <= in_data;
                        e        <= 3'd0;
                        guard    <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (|sh[11:5]) begin
                        sh    <= {1'b0, sh[11:1]};
                        guard <= sh[0];
                        e     <= e + 3'd1;
                    end else begin
                        out_float <= res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_to_float_enc.sv
// tb_fixed_to_float_enc: directed vector table plus backpressure
// and mid-conversion reset sequences for fixed_to_float_enc.
module tb_fixed_to_float_enc;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_float;
    logic        busy;

    int n_tests;
    int n_fail;

    fixed_to_float_enc dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_float (out_float),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] din;
        logic [7:0]  exp_f;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Full transaction; hold = cycles of out_ready=0 after out_valid rises
    task automatic encode(input logic [11:0] d, input logic [7:0] ef,
                          input int lat, input int hold);
        int cyc;
        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 12'hABC;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!out_valid) begin
                check("in_ready_busy", {31'd0, in_ready}, 32'd0);
            end
        end
        check("latency", cyc, lat);
        check("out_float", {24'd0, out_float}, {24'd0, ef});
        check("busy_done", {31'd0, busy}, 32'd1);
        check("in_ready_done", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_float", {24'd0, out_float}, {24'd0, ef});
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("valid_after_hs", {31'd0, out_valid}, 32'd0);
        check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
        check("busy_after_hs", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 12'd0;
        out_ready = 1'b0;

        vecs[0]  = '{12'd6,    8'h06, 1};
        vecs[1]  = '{12'd0,    8'h00, 1};
        vecs[2]  = '{12'd31,   8'h1F, 1};
        vecs[3]  = '{12'd32,   8'h30, 2};
        vecs[4]  = '{12'd100,  8'h59, 3};
        vecs[5]  = '{12'd4095, 8'hFF, 8};
        vecs[6]  = '{12'd2048, 8'hF0, 8};
        vecs[7]  = '{12'd1000, 8'hBF, 6};
        vecs[8]  = '{12'd65,   8'h50, 3};
        vecs[9]  = '{12'd97,   8'h58, 3};
`ifdef FIXED_TO_FLOAT_ROUND_EN
        vecs[10] = '{12'd63,   8'h50, 2};
        vecs[11] = '{12'd99,   8'h59, 3};
`else
        vecs[10] = '{12'd63,   8'h3F, 2};
        vecs[11] = '{12'd99,   8'h58, 3};
`endif

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_float", {24'd0, out_float}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            encode(vecs[i].din, vecs[i].exp_f, vecs[i].exp_lat, 0);
        end

        encode(12'd100, 8'h59, 3, 5);

        @(negedge clk);
        in_data  = 12'd4095;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_float", {24'd0, out_float}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        encode(12'd6, 8'h06, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
